// File: rtl/ddr_pkg.sv
// ddr_pkg
// Shared types and default constants for the DDR game datapath.
//   judge_state_t : state of the hit-judgement FSM
//   DEFAULT_*     : default sizing used by hit_judge and its users
package ddr_pkg;

    // Judgement FSM states.
    //   JUDGE_IDLE   : paused / menu, nothing is judged
    //   JUDGE_OPEN   : current window has not been judged yet
    //   JUDGE_JUDGED : current window already produced its one judgement
    //   JUDGE_OVER   : lives exhausted, terminal until reset
    typedef enum logic [1:0] {
        JUDGE_IDLE   = 2'd0,
        JUDGE_OPEN   = 2'd1,
        JUDGE_JUDGED = 2'd2,
        JUDGE_OVER   = 2'd3
    } judge_state_t;

    localparam int DEFAULT_NUM_LANES   = 4;
    localparam int DEFAULT_MAX_LIVES   = 5;
    localparam int DEFAULT_SCORE_BITS  = 14;
    localparam int DEFAULT_COMBO_BITS  = 14;
    localparam int DEFAULT_COMBO_STEP  = 10;
    localparam int DEFAULT_MULT_MAX    = 8;
    localparam int DEFAULT_BASE_POINTS = 1;

endpackage : ddr_pkg

// File: rtl/hit_judge_rise_detect.sv
// rise_detect
// Registered rising-edge detector for the lane buttons.
//   clk   : system clock
//   reset : synchronous, active-high; clears the history register
//   btn   : debounced button levels, one bit per lane
//   rise  : btn & ~btn_q, high for the first cycle a button is seen high
//
// The history register updates every cycle regardless of game state, so a
// button that is held across a pause never shows up as a late edge.
module rise_detect #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] btn,
    output logic [WIDTH-1:0] rise
);

    logic [WIDTH-1:0] btn_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            btn_q <= '0;
        end else begin
            btn_q <= btn;
        end
    end

    assign rise = btn & ~btn_q;

endmodule : rise_detect

// File: rtl/hit_judge.sv
// hit_judge
// Judges button presses against the arrow at the hit line once per metronome
// window and keeps score, combo, multiplier and lives.
//
// Handshake / timing: there is no valid/ready pair here. beat_tick is a
// one-cycle strobe that closes the current window and latches the next
// target; a button rise is consumed in the cycle it is first sampled. All
// outputs are registered: a judgement made on edge k is visible right after
// edge k and its pulse lasts exactly one cycle.
//
// Ports
//   clk, reset     : system clock, synchronous active-high reset
//   run_en         : high while the game is PLAYING
//   beat_tick      : one-cycle window boundary strobe
//   target         : one-hot arrow at the hit line (0 = no arrow)
//   btn            : debounced button levels
//   score          : accumulated score (saturating)
//   combo          : consecutive correct hits (saturating)
//   multiplier     : current score multiplier (1..MULT_MAX)
//   lives          : remaining lives
//   correct_hit    : one-cycle pulse per correct judgement
//   incorrect_hit  : one-cycle pulse per wrong press or miss
//   game_over      : sticky, set when lives reach 0
//   state          : judgement FSM state, exposed for debug/checkers
module hit_judge
    import ddr_pkg::*;
#(
    parameter int NUM_LANES   = DEFAULT_NUM_LANES,
    parameter int MAX_LIVES   = DEFAULT_MAX_LIVES,
    parameter int SCORE_BITS  = DEFAULT_SCORE_BITS,
    parameter int COMBO_BITS  = DEFAULT_COMBO_BITS,
    parameter int COMBO_STEP  = DEFAULT_COMBO_STEP,
    parameter int MULT_MAX    = DEFAULT_MULT_MAX,
    parameter int BASE_POINTS = DEFAULT_BASE_POINTS,
    localparam int LIFE_BITS  = $clog2(MAX_LIVES + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  run_en,
    input  logic                  beat_tick,
    input  logic [NUM_LANES-1:0]  target,
    input  logic [NUM_LANES-1:0]  btn,
    output logic [SCORE_BITS-1:0] score,
    output logic [COMBO_BITS-1:0] combo,
    output logic [3:0]            multiplier,
    output logic [LIFE_BITS-1:0]  lives,
    output logic                  correct_hit,
    output logic                  incorrect_hit,
    output logic                  game_over,
    output judge_state_t          state
);

    localparam int STEP_BITS = $clog2(COMBO_STEP + 1);
    localparam int SUM_BITS  = SCORE_BITS + 1;

    localparam logic [STEP_BITS-1:0] STEP_LAST  = STEP_BITS'(COMBO_STEP - 1);
    localparam logic [3:0]           MULT_CAP   = 4'(MULT_MAX);
    localparam logic [LIFE_BITS-1:0] LIVES_INIT = LIFE_BITS'(MAX_LIVES);
    localparam logic [SUM_BITS-1:0]  BASE_WIDE  = SUM_BITS'(BASE_POINTS);

    // ------------------------------------------------------------------
    // Edge detection
    // ------------------------------------------------------------------
    logic [NUM_LANES-1:0] rise;

    rise_detect #(
        .WIDTH (NUM_LANES)
    ) u_rise_detect (
        .clk   (clk),
        .reset (reset),
        .btn   (btn),
        .rise  (rise)
    );

    // ------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------
    logic [NUM_LANES-1:0] tgt_q;          // arrow of the window being judged
    logic [STEP_BITS-1:0] step_cnt;       // hits since the last multiplier step
    logic                 resume_judged;  // window state to return to after a pause

    // ------------------------------------------------------------------
    // Judgement decode
    // ------------------------------------------------------------------
    logic active;       // playing and in a window state
    logic window_open;  // the current window can still be judged
    logic press;        // a press is being judged this cycle
    logic hit;
    logic miss;
    logic wrong;

    assign active      = run_en && (state == JUDGE_OPEN || state == JUDGE_JUDGED);
    assign window_open = active && (state == JUDGE_OPEN);
    assign press       = window_open && (|rise);
    // A chord counts only when it matches the arrow exactly; an empty arrow
    // never matches, so any press on it is wrong.
    assign hit         = press && (rise == tgt_q) && (|tgt_q);
    assign wrong       = press && !hit;
    // A press landing on the beat edge belongs to the closing window and
    // therefore suppresses the miss.
    assign miss        = window_open && beat_tick && (|tgt_q) && !(|rise);

    // ------------------------------------------------------------------
    // Next-value arithmetic for a correct hit
    // ------------------------------------------------------------------
    logic [SUM_BITS-1:0]   points;
    logic [SUM_BITS-1:0]   score_sum;
    logic [SCORE_BITS-1:0] score_hit;
    logic [COMBO_BITS-1:0] combo_hit;
    logic [3:0]            mult_hit;
    logic [STEP_BITS-1:0]  step_hit;
    logic [LIFE_BITS-1:0]  lives_dec;

    // Constant times a 4-bit multiplier, computed one bit wider than the
    // score so the carry out can drive the saturation.
    assign points    = BASE_WIDE * {{(SUM_BITS - 4){1'b0}}, multiplier};
    assign score_sum = {1'b0, score} + points;
    assign score_hit = score_sum[SCORE_BITS] ? {SCORE_BITS{1'b1}}
                                             : score_sum[SCORE_BITS-1:0];

    assign combo_hit = (&combo) ? combo : combo + COMBO_BITS'(1);

    always_comb begin
        step_hit = step_cnt + STEP_BITS'(1);
        mult_hit = multiplier;
        if (step_cnt == STEP_LAST) begin
            step_hit = '0;
            if (multiplier < MULT_CAP) begin
                mult_hit = multiplier + 4'd1;
            end
        end
    end

    assign lives_dec = lives - LIFE_BITS'(1);

    // ------------------------------------------------------------------
    // Judgement FSM and scoring registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= JUDGE_IDLE;
            resume_judged <= 1'b0;
            tgt_q         <= '0;
            score         <= '0;
            combo         <= '0;
            step_cnt      <= '0;
            multiplier    <= 4'd1;
            lives         <= LIVES_INIT;
            correct_hit   <= 1'b0;
            incorrect_hit <= 1'b0;
            game_over     <= 1'b0;
        end else begin
            correct_hit   <= 1'b0;
            incorrect_hit <= 1'b0;

            case (state)
                JUDGE_IDLE: begin
                    // The resume cycle itself ignores beat_tick and rises.
                    if (run_en) begin
                        state <= resume_judged ? JUDGE_JUDGED : JUDGE_OPEN;
                    end
                end

                JUDGE_OPEN, JUDGE_JUDGED: begin
                    if (!run_en) begin
                        state         <= JUDGE_IDLE;
                        resume_judged <= (state == JUDGE_JUDGED);
                    end else begin
                        if (beat_tick) begin
                            tgt_q <= target;
                            state <= JUDGE_OPEN;
                        end else if (press) begin
                            state <= JUDGE_JUDGED;
                        end

                        if (hit) begin
                            correct_hit <= 1'b1;
                            score       <= score_hit;
                            combo       <= combo_hit;
                            step_cnt    <= step_hit;
                            multiplier  <= mult_hit;
                        end else if (wrong || miss) begin
                            incorrect_hit <= 1'b1;
                            combo         <= '0;
                            step_cnt      <= '0;
                            multiplier    <= 4'd1;
                            lives         <= lives_dec;
                            // Losing the last life overrides the window
                            // bookkeeping above.
                            if (lives_dec == '0) begin
                                game_over <= 1'b1;
                                state     <= JUDGE_OVER;
                            end
                        end
                    end
                end

                JUDGE_OVER: begin
                    // Frozen until reset.
                end

                default: begin
                    state <= JUDGE_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Invariants
    // ------------------------------------------------------------------
    property p_one_pulse;
        @(posedge clk) disable iff (reset) !(correct_hit && incorrect_hit);
    endproperty
    assert property (p_one_pulse);

    property p_over_sticky;
        @(posedge clk) disable iff (reset) game_over |-> (state == JUDGE_OVER);
    endproperty
    assert property (p_over_sticky);

endmodule : hit_judge

// File: tb/tb_hit_judge.sv
module tb_hit_judge;
  import ddr_pkg::*;

  localparam int LANES     = 4;
  localparam int SCORE_MAX = (1 << 14) - 1;
  localparam int COMBO_MAX = (1 << 14) - 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset;
  logic             run_en;
  logic             beat_tick;
  logic [LANES-1:0] target;
  logic [LANES-1:0] btn;
  logic [13:0]      score;
  logic [13:0]      combo;
  logic [3:0]       multiplier;
  logic [2:0]       lives;
  logic             correct_hit;
  logic             incorrect_hit;
  logic             game_over;
  judge_state_t     dut_state;

  int checks = 0;
  int errors = 0;

  hit_judge dut (
    .clk           (clk),
    .reset         (reset),
    .run_en        (run_en),
    .beat_tick     (beat_tick),
    .target        (target),
    .btn           (btn),
    .score         (score),
    .combo         (combo),
    .multiplier    (multiplier),
    .lives         (lives),
    .correct_hit   (correct_hit),
    .incorrect_hit (incorrect_hit),
    .game_over     (game_over),
    .state         (dut_state)
  );

  // ---------------- reference model (game rules) ----------------
  int         m_score, m_combo, m_mult, m_lives, m_hits_since_step;
  bit         m_over, m_playing, m_judged, m_ch, m_ih;
  logic [3:0] m_tgt, m_prev_btn;

  task automatic model_reset();
    m_score = 0; m_combo = 0; m_mult = 1; m_lives = 5; m_hits_since_step = 0;
    m_over = 0; m_playing = 0; m_judged = 0; m_tgt = 4'b0;
  endtask

  task automatic model_cycle(input bit rst, input bit run, input bit beat,
                             input logic [3:0] tg, input logic [3:0] b);
    logic [3:0] pressed;
    bit judging;
    pressed = b & ~m_prev_btn;
    m_ch = 0;
    m_ih = 0;
    if (rst) begin
      model_reset();
    end else if (!m_over) begin
      if (!m_playing) begin
        if (run) m_playing = 1;
      end else if (!run) begin
        m_playing = 0;
      end else begin
        judging = !m_judged && (pressed != 0);
        if (judging && pressed == m_tgt && m_tgt != 0) begin
          m_ch = 1;
          m_score = m_score + 1 * m_mult;
          if (m_score > SCORE_MAX) m_score = SCORE_MAX;
          if (m_combo < COMBO_MAX) m_combo = m_combo + 1;
          m_hits_since_step = m_hits_since_step + 1;
          if (m_hits_since_step == 10) begin
            m_hits_since_step = 0;
            if (m_mult < 8) m_mult = m_mult + 1;
          end
        end else if (judging || (beat && !m_judged && m_tgt != 0)) begin
          m_ih = 1;
          m_combo = 0;
          m_hits_since_step = 0;
          m_mult = 1;
          m_lives = m_lives - 1;
          if (m_lives == 0) m_over = 1;
        end
        if (beat) begin
          m_tgt = tg;
          m_judged = 0;
        end else if (judging) begin
          m_judged = 1;
        end
      end
    end
    m_prev_btn = rst ? 4'b0 : b;
  endtask

  // ---------------- driver ----------------
  // Inputs change 1 time unit after a rising edge; outputs are sampled at the
  // same point, i.e. away from the active edge.
  task automatic tick(input bit rst, input bit run, input bit beat,
                      input logic [3:0] tg, input logic [3:0] b);
    reset     = rst;
    run_en    = run;
    beat_tick = beat;
    target    = tg;
    btn       = b;
    model_cycle(rst, run, beat, tg, b);
    @(posedge clk);
    #1;
  endtask

  task automatic hit_window(input logic [3:0] lane);
    tick(0, 1, 1, lane, 4'b0);
    tick(0, 1, 0, 4'b0, lane);
    tick(0, 1, 0, 4'b0, 4'b0);
  endtask

  task automatic restart();
    tick(1, 0, 0, 4'b0, 4'b0);
    tick(0, 1, 0, 4'b0, 4'b0);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    m_prev_btn = 4'b0;
    tick(1, 0, 0, 4'b0, 4'b0);
    tick(1, 0, 1, 4'b1111, 4'b1111);
    checks++;
    if ({score, combo, multiplier, lives, correct_hit, incorrect_hit, game_over} !==
        {14'd0, 14'd0, 4'd1, 3'd5, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_values: score=%0d combo=%0d mult=%0d lives=%0d ch=%b ih=%b go=%b, want 0 0 1 5 0 0 0",
               score, combo, multiplier, lives, correct_hit, incorrect_hit, game_over);
    end
  endtask

  task automatic test_first_hit();
    restart();
    tick(0, 1, 1, 4'b0010, 4'b0);
    tick(0, 1, 0, 4'b0, 4'b0);
    tick(0, 1, 0, 4'b0, 4'b0010);
    checks++;
    if ({correct_hit, incorrect_hit, score, combo, multiplier, lives} !==
        {1'b1, 1'b0, 14'd1, 14'd1, 4'd1, 3'd5}) begin
      errors++;
      $display("FAIL first_hit: ch=%b ih=%b score=%0d combo=%0d mult=%0d lives=%0d, want 1 0 1 1 1 5",
               correct_hit, incorrect_hit, score, combo, multiplier, lives);
    end
    tick(0, 1, 0, 4'b0, 4'b0010);
    checks++;
    if (correct_hit !== 1'b0 || score !== 14'd1) begin
      errors++;
      $display("FAIL hit_pulse_width: ch=%b score=%0d, want 0 1", correct_hit, score);
    end
  endtask

  task automatic test_multiplier();
    restart();
    for (int i = 0; i < 10; i++) hit_window(4'b0001);
    checks++;
    if (score !== 14'd10 || combo !== 14'd10 || multiplier !== 4'd2) begin
      errors++;
      $display("FAIL mult_step: score=%0d combo=%0d mult=%0d, want 10 10 2", score, combo, multiplier);
    end
    tick(0, 1, 1, 4'b1000, 4'b0);
    tick(0, 1, 0, 4'b0, 4'b1000);
    checks++;
    if (score !== 14'd12 || combo !== 14'd11 || correct_hit !== 1'b1) begin
      errors++;
      $display("FAIL mult_11th_hit: score=%0d combo=%0d ch=%b, want 12 11 1", score, combo, correct_hit);
    end
    tick(0, 1, 0, 4'b0, 4'b0);
  endtask

  task automatic test_miss();
    tick(0, 1, 1, 4'b0100, 4'b0);
    tick(0, 1, 0, 4'b0, 4'b0);
    checks++;
    if (incorrect_hit !== 1'b0 || lives !== 3'd5) begin
      errors++;
      $display("FAIL miss_early: ih=%b lives=%0d, want 0 5", incorrect_hit, lives);
    end
    tick(0, 1, 1, 4'b0, 4'b0);
    checks++;
    if ({incorrect_hit, correct_hit, combo, multiplier, lives, score} !==
        {1'b1, 1'b0, 14'd0, 4'd1, 3'd4, 14'd12}) begin
      errors++;
      $display("FAIL miss: ih=%b ch=%b combo=%0d mult=%0d lives=%0d score=%0d, want 1 0 0 1 4 12",
               incorrect_hit, correct_hit, combo, multiplier, lives, score);
    end
  endtask

  task automatic test_wrong_chord();
    tick(0, 1, 1, 4'b0001, 4'b0);
    tick(0, 1, 0, 4'b0, 4'b0101);
    checks++;
    if (incorrect_hit !== 1'b1 || correct_hit !== 1'b0 || lives !== 3'd3) begin
      errors++;
      $display("FAIL wrong_chord: ih=%b ch=%b lives=%0d, want 1 0 3", incorrect_hit, correct_hit, lives);
    end
    tick(0, 1, 0, 4'b0, 4'b0);
    tick(0, 1, 0, 4'b0, 4'b0001);
    checks++;
    if (incorrect_hit !== 1'b0 || correct_hit !== 1'b0 || lives !== 3'd3 || score !== 14'd12) begin
      errors++;
      $display("FAIL second_press: ih=%b ch=%b lives=%0d score=%0d, want 0 0 3 12",
               incorrect_hit, correct_hit, lives, score);
    end
    tick(0, 1, 1, 4'b0, 4'b0);
    checks++;
    if (incorrect_hit !== 1'b0 || lives !== 3'd3) begin
      errors++;
      $display("FAIL judged_close: ih=%b lives=%0d, want 0 3", incorrect_hit, lives);
    end
  endtask

  task automatic test_game_over();
    restart();
    tick(0, 1, 1, 4'b1000, 4'b0);
    for (int i = 0; i < 5; i++) tick(0, 1, 1, 4'b1000, 4'b0);
    checks++;
    if (lives !== 3'd0 || game_over !== 1'b1 || incorrect_hit !== 1'b1 || dut_state !== JUDGE_OVER) begin
      errors++;
      $display("FAIL game_over: lives=%0d go=%b ih=%b state=%0d, want 0 1 1 3",
               lives, game_over, incorrect_hit, dut_state);
    end
    tick(0, 1, 1, 4'b1000, 4'b0);
    tick(0, 1, 0, 4'b0, 4'b1000);
    tick(0, 1, 1, 4'b0001, 4'b0);
    checks++;
    if ({correct_hit, incorrect_hit, score, lives, game_over} !== {1'b0, 1'b0, 14'd0, 3'd0, 1'b1}) begin
      errors++;
      $display("FAIL over_frozen: ch=%b ih=%b score=%0d lives=%0d go=%b, want 0 0 0 0 1",
               correct_hit, incorrect_hit, score, lives, game_over);
    end
    tick(1, 0, 0, 4'b0, 4'b0);
    checks++;
    if (lives !== 3'd5 || game_over !== 1'b0) begin
      errors++;
      $display("FAIL over_reset: lives=%0d go=%b, want 5 0", lives, game_over);
    end
  endtask

  task automatic test_coincide_and_pause();
    restart();
    tick(0, 1, 1, 4'b0010, 4'b0);
    tick(0, 1, 0, 4'b0, 4'b0);
    tick(0, 1, 1, 4'b0100, 4'b0010);
    checks++;
    if ({correct_hit, incorrect_hit, score, lives} !== {1'b1, 1'b0, 14'd1, 3'd5}) begin
      errors++;
      $display("FAIL beat_press: ch=%b ih=%b score=%0d lives=%0d, want 1 0 1 5",
               correct_hit, incorrect_hit, score, lives);
    end
    // Pause in an open window: presses and beats are ignored.
    tick(0, 0, 0, 4'b0, 4'b0);
    tick(0, 0, 1, 4'b0001, 4'b0100);
    checks++;
    if (correct_hit !== 1'b0 || incorrect_hit !== 1'b0 || score !== 14'd1) begin
      errors++;
      $display("FAIL paused_press: ch=%b ih=%b score=%0d, want 0 0 1", correct_hit, incorrect_hit, score);
    end
    tick(0, 0, 0, 4'b0, 4'b0);
    tick(0, 1, 0, 4'b0, 4'b0);
    tick(0, 1, 0, 4'b0, 4'b0100);
    checks++;
    if (correct_hit !== 1'b1 || score !== 14'd2 || combo !== 14'd2) begin
      errors++;
      $display("FAIL resume_open: ch=%b score=%0d combo=%0d, want 1 2 2", correct_hit, score, combo);
    end
    // Pause in a judged window: it stays judged after resume.
    tick(0, 0, 0, 4'b0, 4'b0);
    tick(0, 1, 0, 4'b0, 4'b0);
    tick(0, 1, 0, 4'b0, 4'b0001);
    checks++;
    if (correct_hit !== 1'b0 || incorrect_hit !== 1'b0 || lives !== 3'd5) begin
      errors++;
      $display("FAIL resume_judged: ch=%b ih=%b lives=%0d, want 0 0 5", correct_hit, incorrect_hit, lives);
    end
    tick(0, 1, 1, 4'b0, 4'b0);
    checks++;
    if (incorrect_hit !== 1'b0 || lives !== 3'd5) begin
      errors++;
      $display("FAIL resume_judged_close: ih=%b lives=%0d, want 0 5", incorrect_hit, lives);
    end
  endtask

  task automatic test_random();
    logic [3:0]  tg, b;
    bit          rst, run, beat;
    int          r;
    int          shown = 0;
    logic [38:0] got, want;
    restart();
    for (int i = 0; i < 4000; i++) begin
      rst  = ($urandom_range(0, 399) == 0);
      run  = ($urandom_range(0, 19) != 0);
      beat = ($urandom_range(0, 4) == 0);
      r = $urandom_range(0, 5);
      tg = (r >= 4) ? 4'b0 : (4'b0001 << r);
      r = $urandom_range(0, 9);
      if (r < 4)       b = m_tgt;
      else if (r == 4) b = 4'($urandom_range(0, 15));
      else             b = 4'b0;
      tick(rst, run, beat, tg, b);
      got  = {score, combo, multiplier, lives, correct_hit, incorrect_hit, game_over};
      want = {14'(m_score), 14'(m_combo), 4'(m_mult), 3'(m_lives), m_ch, m_ih, m_over};
      checks++;
      if (got !== want) begin
        errors++;
        if (shown < 10) begin
          shown++;
          $display("FAIL random cycle %0d: score=%0d combo=%0d mult=%0d lives=%0d ch=%b ih=%b go=%b, want %0d %0d %0d %0d %b %b %b",
                   i, score, combo, multiplier, lives, correct_hit, incorrect_hit, game_over,
                   m_score, m_combo, m_mult, m_lives, m_ch, m_ih, m_over);
        end
      end
    end
  endtask

  initial begin
    reset = 1'b1; run_en = 1'b0; beat_tick = 1'b0; target = '0; btn = '0;
    test_reset();
    test_first_hit();
    test_multiplier();
    test_miss();
    test_wrong_chord();
    test_game_over();
    test_coincide_and_pause();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_hit_judge
